// File: rtl/rf_pkg.sv
// Shared constants and types for the multiport register file and its dump sequencer.
package rf_pkg;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_DEPTH  = 16;
  localparam int DEF_NUM_RD = 2;
  localparam int ZERO_REG   = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DUMP = 2'd1,
    DONE = 2'd2
  } rf_dump_state_t;
endpackage

// File: rtl/rf_multiport_if.sv
// Read/write/dump bundle for rf_multiport; master drives requests, slave is the register file.
interface rf_multiport_if #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int NUM_RD = 2,
  localparam int ADDR_W = $clog2(DEPTH)
);
  logic [NUM_RD-1:0]        rd_en;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic                     we;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     hlt;
  logic                     dump_valid;
  logic [ADDR_W-1:0]        dump_addr;
  logic [DATA_W-1:0]        dump_data;
  logic                     dump_done;

  modport master (
    output rd_en, rd_addr, we, wr_addr, wr_data, hlt,
    input  rd_data, dump_valid, dump_addr, dump_data, dump_done
  );

  modport slave (
    input  rd_en, rd_addr, we, wr_addr, wr_data, hlt,
    output rd_data, dump_valid, dump_addr, dump_data, dump_done
  );
endinterface

// File: rtl/rf_dump_seq.sv
// Halt-dump sequencer: on a rising hlt edge streams registers 1..DEPTH-1, one per cycle,
// then holds dump_done until hlt falls.
module rf_dump_seq
  import rf_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hlt,
  output logic [ADDR_W-1:0] rd_idx,
  input  logic [DATA_W-1:0] rd_val,
  output logic              dump_valid,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_done
);
  rf_dump_state_t    state_reg;
  logic [ADDR_W-1:0] idx_reg;
  logic              hlt_q_reg;
  logic              valid_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] data_reg;
  logic              done_reg;

  assign rd_idx     = idx_reg;
  assign dump_valid = valid_reg;
  assign dump_addr  = addr_reg;
  assign dump_data  = data_reg;
  assign dump_done  = done_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      hlt_q_reg <= 1'b0;
      valid_reg <= 1'b0;
      addr_reg  <= '0;
      data_reg  <= '0;
      done_reg  <= 1'b0;
    end else begin
      hlt_q_reg <= hlt;
      case (state_reg)
        IDLE: begin
          valid_reg <= 1'b0;
          done_reg  <= 1'b0;
          if (hlt && !hlt_q_reg) begin
            state_reg <= DUMP;
            idx_reg   <= ADDR_W'(1);
          end
        end
        DUMP: begin
          valid_reg <= 1'b1;
          addr_reg  <= idx_reg;
          data_reg  <= rd_val;
          idx_reg   <= idx_reg + ADDR_W'(1);
          if (idx_reg == ADDR_W'(DEPTH - 1))
            state_reg <= DONE;
        end
        DONE: begin
          // done is shown for at least one cycle even if hlt already dropped mid-dump
          valid_reg <= 1'b0;
          if (done_reg && !hlt) begin
            done_reg  <= 1'b0;
            state_reg <= IDLE;
          end else begin
            done_reg <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: rtl/rf_multiport.sv
// Parametrised register file with NUM_RD registered read ports, one write port and a halt dump.
// Define RF_BYPASS_EN to forward same-cycle write data to colliding reads and dump samples.
module rf_multiport
  import rf_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int NUM_RD = DEF_NUM_RD,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input logic          clk,
  input logic          rst,
  rf_multiport_if.slave bus
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_hit;
  logic [ADDR_W-1:0] dump_idx;
  logic [DATA_W-1:0] dump_val;

  assign wr_hit = bus.we && (bus.wr_addr != ADDR_W'(ZERO_REG));

  // entry 0 is never written, so resetting it is enough to keep it zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_hit) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] rv;
      logic [DATA_W-1:0] rd_data_reg;

      assign ra = bus.rd_addr[gi*ADDR_W +: ADDR_W];
`ifdef RF_BYPASS_EN
      assign rv = (wr_hit && ra == bus.wr_addr) ? bus.wr_data : mem[ra];
`else
      assign rv = mem[ra];
`endif

      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          rd_data_reg <= '0;
        else if (bus.rd_en[gi])
          rd_data_reg <= rv;
      end

      assign bus.rd_data[gi*DATA_W +: DATA_W] = rd_data_reg;
    end
  endgenerate

`ifdef RF_BYPASS_EN
  assign dump_val = (wr_hit && dump_idx == bus.wr_addr) ? bus.wr_data : mem[dump_idx];
`else
  assign dump_val = mem[dump_idx];
`endif

  rf_dump_seq #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_dump_seq (
    .clk       (clk),
    .rst       (rst),
    .hlt       (bus.hlt),
    .rd_idx    (dump_idx),
    .rd_val    (dump_val),
    .dump_valid(bus.dump_valid),
    .dump_addr (bus.dump_addr),
    .dump_data (bus.dump_data),
    .dump_done (bus.dump_done)
  );
endmodule

// File: tb/tb_rf_multiport.sv
// Scoreboard bench for rf_multiport: a stimulus process pushes per-cycle expectations from a
// behavioural model, a negedge monitor pops and compares them.
module tb_rf_multiport;
  localparam int DW = 16;
  localparam int DP = 16;
  localparam int NR = 2;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rf_multiport_if #(.DATA_W(DW), .DEPTH(DP), .NUM_RD(NR)) bus ();

  rf_multiport #(.DATA_W(DW), .DEPTH(DP), .NUM_RD(NR)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int            due;
    bit            is_dump;
    int            port;
    logic [DW-1:0] data;
    logic [AW-1:0] addr;
    logic          valid;
    logic          done;
  } exp_t;

  exp_t sbq[$];
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // reference model state
  logic [DW-1:0] mem_m [DP];
  logic [DW-1:0] last_rd [NR];
  logic          hlt_prev;
  int            k;
  bit            finishing;
  bit            done_out;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] peek(input logic [AW-1:0] a, input logic w,
                                         input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    if (a == 0) return '0;
`ifdef RF_BYPASS_EN
    if (w && wa == a) return wd;
`endif
    return mem_m[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DP; i++) mem_m[i] = '0;
    for (int i = 0; i < NR; i++) last_rd[i] = '0;
    hlt_prev = 1'b0;
    k = 0;
    finishing = 0;
    done_out = 0;
  endtask

  task automatic step(input logic [NR-1:0] en, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                      input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input logic h);
    logic [AW-1:0] ra [NR];
    logic [DW-1:0] v;
    exp_t e;
    ra[0] = a0;
    ra[1] = a1;
    bus.rd_en   = en;
    bus.rd_addr = {a1, a0};
    bus.we      = w;
    bus.wr_addr = wa;
    bus.wr_data = wd;
    bus.hlt     = h;
    for (int i = 0; i < NR; i++) begin
      v = en[i] ? peek(ra[i], w, wa, wd) : last_rd[i];
      last_rd[i] = v;
      e = '{due: cyc + 1, is_dump: 1'b0, port: i, data: v, addr: '0, valid: 1'b0, done: 1'b0};
      sbq.push_back(e);
    end
    e = '{due: cyc + 1, is_dump: 1'b1, port: 0, data: '0, addr: '0, valid: 1'b0, done: 1'b0};
    if (k != 0) begin
      e.valid = 1'b1;
      e.addr  = AW'(k);
      e.data  = peek(AW'(k), w, wa, wd);
      if (k == DP - 1) begin
        k = 0;
        finishing = 1;
      end else begin
        k++;
      end
    end else if (finishing) begin
      finishing = 0;
      done_out = 1;
      e.done = 1'b1;
    end else if (done_out) begin
      if (!h) done_out = 0;
      e.done = done_out;
    end else if (h && !hlt_prev) begin
      k = 1;
    end
    sbq.push_back(e);
    hlt_prev = h;
    if (w && wa != 0) mem_m[wa] = wd;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    while (sbq.size() > 0 && sbq[0].due <= cyc) begin
      e = sbq.pop_front();
      if (e.is_dump) begin
        check("dump_valid", 32'(bus.dump_valid), 32'(e.valid));
        check("dump_done", 32'(bus.dump_done), 32'(e.done));
        if (e.valid) begin
          check("dump_addr", 32'(bus.dump_addr), 32'(e.addr));
          check("dump_data", 32'(bus.dump_data), 32'(e.data));
        end
      end else begin
        check($sformatf("rd_data%0d", e.port), 32'(bus.rd_data[e.port*DW +: DW]), 32'(e.data));
      end
    end
  end

  task automatic idle_inputs();
    bus.rd_en = '0;
    bus.rd_addr = '0;
    bus.we = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.hlt = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int i = 0; i < NR; i++)
      check($sformatf("%s_rd_data%0d", tag, i), 32'(bus.rd_data[i*DW +: DW]), 32'h0);
    check({tag, "_dump_valid"}, 32'(bus.dump_valid), 32'h0);
    check({tag, "_dump_addr"}, 32'(bus.dump_addr), 32'h0);
    check({tag, "_dump_data"}, 32'(bus.dump_data), 32'h0);
    check({tag, "_dump_done"}, 32'(bus.dump_done), 32'h0);
  endtask

  task automatic do_reset(input int n);
    sbq.delete();
    idle_inputs();
    rst = 1'b1;
    #1;
    check_reset_outputs("reset");
    repeat (n) @(posedge clk);
    #1;
    model_reset();
    rst = 1'b0;
  endtask

  task automatic read_all();
    for (int a = 0; a < DP; a++) step(2'b11, AW'(a), AW'(a), 1'b0, '0, '0, 1'b0);
  endtask

  task automatic random_run(input int n, input bit use_hlt);
    logic h;
    h = 1'b0;
    for (int t = 0; t < n; t++) begin
      if (use_hlt && $urandom_range(0, 11) == 0) h = ~h;
      step(NR'($urandom), AW'($urandom), AW'($urandom), 1'($urandom),
           AW'($urandom), DW'($urandom), h);
    end
  endtask

  initial begin
    idle_inputs();
    model_reset();
    @(posedge clk);
    #1;
    do_reset(3);

    read_all();

    // basic write/read and the hardwired zero register
    step(2'b00, '0, '0, 1'b1, 4'd5, 16'hA5A5, 1'b0);
    step(2'b11, 4'd5, 4'd5, 1'b0, '0, '0, 1'b0);
    step(2'b00, '0, '0, 1'b1, 4'd0, 16'hFFFF, 1'b0);
    step(2'b11, 4'd0, 4'd0, 1'b0, '0, '0, 1'b0);

    // same-cycle collision, then the following read
    step(2'b00, '0, '0, 1'b1, 4'd3, 16'h0001, 1'b0);
    step(2'b11, 4'd3, 4'd3, 1'b1, 4'd3, 16'h1234, 1'b0);
    step(2'b11, 4'd3, 4'd3, 1'b0, '0, '0, 1'b0);

    // port 1 disabled while its address and the memory change
    step(2'b11, 4'd7, 4'd7, 1'b1, 4'd7, 16'h1111, 1'b0);
    step(2'b11, 4'd7, 4'd7, 1'b0, '0, '0, 1'b0);
    for (int i = 0; i < 3; i++)
      step(2'b01, 4'd7, AW'(8 + i), 1'b1, 4'd7, DW'(16'h2220 + i), 1'b0);

    random_run(300, 1'b0);

    // full dump of a known pattern, hlt held, then released
    for (int i = 1; i < DP; i++) step(2'b00, '0, '0, 1'b1, AW'(i), DW'(16'h1000 + i), 1'b0);
    for (int i = 0; i < 20; i++) step(2'b00, '0, '0, 1'b0, '0, '0, 1'b1);
    for (int i = 0; i < 3; i++) step(2'b00, '0, '0, 1'b0, '0, '0, 1'b0);

    // reset in the middle of a dump
    step(2'b00, '0, '0, 1'b0, '0, '0, 1'b1);
    while (k != 5) step(2'b00, '0, '0, 1'b0, '0, '0, 1'b1);
    @(negedge clk);
    #1;
    sbq.delete();
    rst = 1'b1;
    #1;
    check_reset_outputs("middump");
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst = 1'b0;
    read_all();
    for (int i = 0; i < 18; i++) step(2'b00, '0, '0, 1'b0, '0, '0, 1'b1);
    for (int i = 0; i < 3; i++) step(2'b00, '0, '0, 1'b0, '0, '0, 1'b0);

    // random traffic with dumps overlapping reads and writes
    random_run(600, 1'b1);

    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(sbq.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
